argmax_10class: RTL and testbench
=================================

# argmax_10class

Consumes the per-cycle class index and frame-start pulse produced by the 10-state class sequencer, together with one signed score per class from the output layer, and tracks the running maximum across a 10-class frame. At the end of each complete frame it publishes the winning digit (0-9) and its score through a valid/ready output register. It sits directly downstream of the class sequencer and the output-layer MAC, and feeds the result display/UART logic.

## Interface
- NUM_CLASSES, 10, classes per frame; legal range 2-16.
- SCORE_W, 16, width of the two's-complement class score.
- i_clk  in  1  system clock, all logic on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_state  in  4  class index from the sequencer, 0..NUM_CLASSES-1.
- i_transition  in  1  frame-start pulse; high in the cycle where i_state==0 begins a new frame.
- i_score  in  SCORE_W  signed score for class i_state.
- i_score_valid  in  1  i_score/i_state/i_transition are meaningful this cycle.
- i_ready  in  1  downstream accepts the result when o_valid && i_ready.
- o_valid  out  1  result register holds an unconsumed result.
- o_digit  out  4  winning class index.
- o_score  out  SCORE_W  winning score (signed).
- o_overrun  out  1  one-cycle pulse: completed frame dropped because the output was full.
- o_seq_err  out  1  one-cycle pulse: out-of-order sample, frame discarded.
- o_frame_cnt  out  16  count of published results, wraps 0xFFFF->0.

## Operation
- FSM states: S_WAIT (unsynchronised), S_ACC (accumulating). Reset state S_WAIT.
- Frame start = i_score_valid && i_transition && i_state==0.
- S_WAIT: frame start loads best_score=i_score, best_idx=0, exp_idx=1, goes to S_ACC; all other samples ignored, no error.
- S_ACC, i_score_valid low: hold, no timeout.
- S_ACC, valid sample with i_state==exp_idx and i_transition low: if i_score > best_score (signed, strict) then best_score=i_score, best_idx=i_state; exp_idx increments.
- Ties: lower index wins (strict greater-than).
- Sample with i_state==NUM_CLASSES-1 accepted: publish max(best, this sample) and return to S_WAIT.
- S_ACC, valid sample with i_state!=exp_idx, or i_transition high: pulse o_seq_err, discard frame. If that sample is itself a frame start, restart accumulation from it (stay in S_ACC, exp_idx=1); otherwise go to S_WAIT.
- Publish: if !o_valid or (o_valid && i_ready) in the publish cycle, load o_digit/o_score, set o_valid, increment o_frame_cnt. Else keep old result, pulse o_overrun, o_frame_cnt unchanged.
- o_valid && i_ready with no publish: clear o_valid; o_digit/o_score hold last values.
- Score compare is full SCORE_W signed; no saturation or widening.

## Timing
- Reset (async assert, any cycle incl. mid-frame): o_valid=0, o_digit=0, o_score=0, o_overrun=0, o_seq_err=0, o_frame_cnt=0, FSM=S_WAIT, partial frame lost. Deassertion synchronous to i_clk is the integrator's responsibility.
- Latency: last class sample accepted at edge t -> o_valid/o_digit/o_score valid after edge t (visible cycle t+1).
- Back-to-back frames with a free-running sequencer (state 9 then state 0 + transition next cycle) are accepted with no lost cycle: S_WAIT accepts the frame start in the cycle immediately after publish.
- o_seq_err and o_overrun are registered, high exactly one cycle after the offending edge.
- Throughput: one result per NUM_CLASSES cycles; output register sustains this when i_ready held high.

## Test plan
- Single frame, scores 5,3,9,1,0,-2,9,4,7,8 (class 0..9), i_ready=1 -> o_valid one cycle after class 9, o_digit=2, o_score=9 (tie with class 6 resolved to lower index), o_frame_cnt=1.
- All-negative frame -100,-50,-7,-300,... (class 2 = -7 maximum) -> o_digit=2, o_score=0xFFF9; confirms signed compare.
- Free-running sequencer, 3 frames, i_ready=0 -> first result held, o_overrun pulses twice, o_frame_cnt=1; raise i_ready -> o_valid drops next cycle.
- Sequence 0,1,2,4 (skip 3) -> o_seq_err pulse, no result; next clean frame with max 0x7FFF at class 9 -> o_digit=9, o_score=0x7FFF.
- Samples before first i_transition ignored; assert i_rst_n low at class 5 of a frame -> all outputs 0 immediately, next full frame publishes correctly.
- Publish in the same cycle as o_valid && i_ready -> new result loaded, no o_overrun, o_frame_cnt increments.

Source files
------------

// File: rtl/argmax_10class.sv
// Running arg-max over one frame of class scores from the class sequencer.
// Publishes the winning class and its score through a valid/ready result register.
module argmax_10class #(
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_W     = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [3:0]                i_state,
    input  logic                      i_transition,
    input  logic signed [SCORE_W-1:0] i_score,
    input  logic                      i_score_valid,
    input  logic                      i_ready,
    output logic                      o_valid,
    output logic [3:0]                o_digit,
    output logic signed [SCORE_W-1:0] o_score,
    output logic                      o_overrun,
    output logic                      o_seq_err,
    output logic [15:0]               o_frame_cnt
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);

    typedef enum logic {S_WAIT, S_ACC} state_t;

    // Strict signed compare: on a tie the earlier (lower) class keeps the lead.
    function automatic logic beats(input logic signed [SCORE_W-1:0] cand,
                                   input logic signed [SCORE_W-1:0] best);
        return cand > best;
    endfunction

    state_t                      state_q, state_d;
    logic signed [SCORE_W-1:0]   best_score_q, best_score_d;
    logic [3:0]                  best_idx_q, best_idx_d;
    logic [3:0]                  exp_idx_q, exp_idx_d;
    logic                        valid_q, valid_d;
    logic [3:0]                  digit_q, digit_d;
    logic signed [SCORE_W-1:0]   score_q, score_d;
    logic                        overrun_q, overrun_d;
    logic                        seq_err_q, seq_err_d;
    logic [15:0]                 frame_cnt_q, frame_cnt_d;

    logic                        frame_start;
    logic                        publish;
    logic [3:0]                  pub_idx;
    logic signed [SCORE_W-1:0]   pub_score;

    assign frame_start = i_score_valid && i_transition && (i_state == 4'd0);

    always_comb begin
        state_d      = state_q;
        best_score_d = best_score_q;
        best_idx_d   = best_idx_q;
        exp_idx_d    = exp_idx_q;
        publish      = 1'b0;
        pub_idx      = best_idx_q;
        pub_score    = best_score_q;
        seq_err_d    = 1'b0;

        case (state_q)
            S_WAIT: begin
                if (frame_start) begin
                    best_score_d = i_score;
                    best_idx_d   = 4'd0;
                    exp_idx_d    = 4'd1;
                    state_d      = S_ACC;
                end
            end
            S_ACC: begin
                if (i_score_valid) begin
                    if (!i_transition && (i_state == exp_idx_q)) begin
                        if (beats(i_score, best_score_q)) begin
                            pub_idx   = i_state;
                            pub_score = i_score;
                        end
                        if (i_state == LAST_IDX) begin
                            publish = 1'b1;
                            state_d = S_WAIT;
                        end else begin
                            best_score_d = pub_score;
                            best_idx_d   = pub_idx;
                            exp_idx_d    = exp_idx_q + 4'd1;
                        end
                    end else begin
                        // Out-of-order sample: drop the frame, but a fresh frame start restarts at once.
                        seq_err_d = 1'b1;
                        if (frame_start) begin
                            best_score_d = i_score;
                            best_idx_d   = 4'd0;
                            exp_idx_d    = 4'd1;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_comb begin
        valid_d     = valid_q;
        digit_d     = digit_q;
        score_d     = score_q;
        frame_cnt_d = frame_cnt_q;
        overrun_d   = 1'b0;

        if (publish) begin
            // A result consumed in this same cycle frees the register for the new one.
            if (!valid_q || i_ready) begin
                valid_d     = 1'b1;
                digit_d     = pub_idx;
                score_d     = pub_score;
                frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_WAIT;
            best_score_q <= '0;
            best_idx_q   <= '0;
            exp_idx_q    <= '0;
            valid_q      <= 1'b0;
            digit_q      <= '0;
            score_q      <= '0;
            overrun_q    <= 1'b0;
            seq_err_q    <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            best_score_q <= best_score_d;
            best_idx_q   <= best_idx_d;
            exp_idx_q    <= exp_idx_d;
            valid_q      <= valid_d;
            digit_q      <= digit_d;
            score_q      <= score_d;
            overrun_q    <= overrun_d;
            seq_err_q    <= seq_err_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_digit     = digit_q;
    assign o_score     = score_q;
    assign o_overrun   = overrun_q;
    assign o_seq_err   = seq_err_q;
    assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_argmax_10class.sv
// Directed bench for argmax_10class: hand-computed frames, sequencing errors,
// overrun/back-pressure and mid-frame reset.
module tb_argmax_10class;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [3:0]         st;
    logic               tr;
    logic signed [15:0] sc;
    logic               sv;
    logic               rdy;
    logic               o_valid;
    logic [3:0]         o_digit;
    logic signed [15:0] o_score;
    logic               o_overrun;
    logic               o_seq_err;
    logic [15:0]        o_frame_cnt;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;
    int ovr_cnt = 0;
    int err_cnt = 0;
    logic signed [15:0] fr [10];

    argmax_10class #(.NUM_CLASSES(10), .SCORE_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_state(st), .i_transition(tr),
        .i_score(sc), .i_score_valid(sv), .i_ready(rdy),
        .o_valid(o_valid), .o_digit(o_digit), .o_score(o_score),
        .o_overrun(o_overrun), .o_seq_err(o_seq_err), .o_frame_cnt(o_frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_overrun) ovr_cnt <= ovr_cnt + 1;
        if (o_seq_err) err_cnt <= err_cnt + 1;
    end

    task automatic sample(input logic [3:0] s, input logic t, input logic signed [15:0] v, input logic r);
        @(negedge clk);
        st = s; tr = t; sc = v; sv = 1'b1; rdy = r;
    endtask

    task automatic idle(input logic r);
        @(negedge clk);
        sv = 1'b0; tr = 1'b0; rdy = r;
        @(posedge clk); #1;
    endtask

    // Drives fr[0..9] as one clean frame; returns just after the last sample's edge.
    task automatic run_frame(input logic r_body, input logic r_last);
        for (int k = 0; k < 10; k++)
            sample(4'(k), (k == 0), fr[k], (k == 9) ? r_last : r_body);
        @(posedge clk); #1;
    endtask

    task automatic fill(input logic signed [15:0] base, input int idx, input logic signed [15:0] v);
        for (int k = 0; k < 10; k++) fr[k] = base;
        fr[idx] = v;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; st = '0; tr = 0; sc = '0; sv = 0; rdy = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
        checks++; if (o_digit !== 4'd0) begin errors++; $display("FAIL reset_digit got=%0d exp=0", o_digit); end
        checks++; if (o_score !== 16'sd0) begin errors++; $display("FAIL reset_score got=%h exp=0000", o_score); end
        checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", o_overrun); end
        checks++; if (o_seq_err !== 1'b0) begin errors++; $display("FAIL reset_seq_err got=%b exp=0", o_seq_err); end
        checks++; if (o_frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", o_frame_cnt); end
        @(negedge clk); rst_n = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_single_frame;
        fr = '{16'sd5, 16'sd3, 16'sd9, 16'sd1, 16'sd0, -16'sd2, 16'sd9, 16'sd4, 16'sd7, 16'sd8};
        for (int k = 0; k < 9; k++) sample(4'(k), (k == 0), fr[k], 1'b1);
        @(posedge clk); #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got=%b exp=0", o_valid); end
        sample(4'd9, 1'b0, fr[9], 1'b1);
        @(posedge clk); #1;
        exp_cnt++;
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", o_valid); end
        checks++; if (o_digit !== 4'd2) begin errors++; $display("FAIL single_digit got=%0d exp=2", o_digit); end
        checks++; if (o_score !== 16'sd9) begin errors++; $display("FAIL single_score got=%h exp=0009", o_score); end
        checks++; if (o_frame_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL single_cnt got=%0d exp=%0d", o_frame_cnt, exp_cnt); end
        idle(1'b1);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL single_consume got=%b exp=0", o_valid); end
        checks++; if (o_digit !== 4'd2) begin errors++; $display("FAIL single_hold_digit got=%0d exp=2", o_digit); end
    endtask

    task automatic test_negative;
        fr = '{-16'sd100, -16'sd50, -16'sd7, -16'sd300, -16'sd1000, -16'sd20, -16'sd8, -16'sd9, -16'sd32768, -16'sd15};
        run_frame(1'b1, 1'b1);
        exp_cnt++;
        checks++; if (o_digit !== 4'd2) begin errors++; $display("FAIL neg_digit got=%0d exp=2", o_digit); end
        checks++; if (o_score !== 16'shFFF9) begin errors++; $display("FAIL neg_score got=%h exp=fff9", o_score); end
        checks++; if (o_frame_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL neg_cnt got=%0d exp=%0d", o_frame_cnt, exp_cnt); end
        idle(1'b1);
    endtask

    task automatic test_overrun;
        int ovr0;
        ovr0 = ovr_cnt;
        fill(16'sd0, 4, 16'sd100);
        run_frame(1'b0, 1'b0);
        exp_cnt++;
        checks++; if (o_valid !== 1'b1 || o_digit !== 4'd4) begin errors++; $display("FAIL ovr_first got=%b/%0d exp=1/4", o_valid, o_digit); end
        fill(16'sd0, 1, 16'sd200);
        run_frame(1'b0, 1'b0);
        checks++; if (o_overrun !== 1'b1) begin errors++; $display("FAIL ovr_pulse1 got=%b exp=1", o_overrun); end
        checks++; if (o_digit !== 4'd4 || o_score !== 16'sd100) begin errors++; $display("FAIL ovr_hold got=%0d/%h exp=4/0064", o_digit, o_score); end
        fill(16'sd0, 8, 16'sd300);
        run_frame(1'b0, 1'b0);
        checks++; if (o_overrun !== 1'b1) begin errors++; $display("FAIL ovr_pulse2 got=%b exp=1", o_overrun); end
        idle(1'b0);
        checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got=%b exp=0", o_overrun); end
        checks++; if (ovr_cnt - ovr0 !== 2) begin errors++; $display("FAIL ovr_count got=%0d exp=2", ovr_cnt - ovr0); end
        checks++; if (o_frame_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL ovr_cnt got=%0d exp=%0d", o_frame_cnt, exp_cnt); end
        checks++; if (o_valid !== 1'b1 || o_digit !== 4'd4) begin errors++; $display("FAIL ovr_still got=%b/%0d exp=1/4", o_valid, o_digit); end
        idle(1'b1);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain got=%b exp=0", o_valid); end
    endtask

    task automatic test_seq_err;
        int e0;
        e0 = err_cnt;
        sample(4'd0, 1'b1, 16'sd10, 1'b1);
        sample(4'd1, 1'b0, 16'sd11, 1'b1);
        sample(4'd2, 1'b0, 16'sd12, 1'b1);
        sample(4'd4, 1'b0, 16'sd14, 1'b1);
        @(posedge clk); #1;
        checks++; if (o_seq_err !== 1'b1) begin errors++; $display("FAIL seq_pulse got=%b exp=1", o_seq_err); end
        idle(1'b1);
        checks++; if (o_seq_err !== 1'b0) begin errors++; $display("FAIL seq_clear got=%b exp=0", o_seq_err); end
        // Rest of the broken frame must be ignored in the unsynchronised state.
        for (int k = 5; k < 10; k++) sample(4'(k), 1'b0, 16'sd20000, 1'b1);
        idle(1'b1);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL seq_no_result got=%b exp=0", o_valid); end
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL seq_count got=%0d exp=1", err_cnt - e0); end
        fill(16'sd5, 0, 16'sd32766);
        fr[9] = 16'sh7FFF;
        run_frame(1'b1, 1'b1);
        exp_cnt++;
        checks++; if (o_digit !== 4'd9) begin errors++; $display("FAIL seq_next_digit got=%0d exp=9", o_digit); end
        checks++; if (o_score !== 16'sh7FFF) begin errors++; $display("FAIL seq_next_score got=%h exp=7fff", o_score); end
        idle(1'b1);
    endtask

    task automatic test_restart;
        int e0;
        e0 = err_cnt;
        sample(4'd0, 1'b1, 16'sd1, 1'b1);
        sample(4'd1, 1'b0, 16'sd20000, 1'b1);
        sample(4'd2, 1'b0, 16'sd2, 1'b1);
        fill(-16'sd3, 5, 16'sd50);
        run_frame(1'b1, 1'b1);
        exp_cnt++;
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL restart_err got=%0d exp=1", err_cnt - e0); end
        checks++; if (o_valid !== 1'b1 || o_digit !== 4'd5) begin errors++; $display("FAIL restart_digit got=%b/%0d exp=1/5", o_valid, o_digit); end
        checks++; if (o_score !== 16'sd50) begin errors++; $display("FAIL restart_score got=%h exp=0032", o_score); end
        idle(1'b1);
    endtask

    task automatic test_reset_midframe;
        sample(4'd0, 1'b0, 16'sd30000, 1'b0);
        sample(4'd1, 1'b0, 16'sd30000, 1'b0);
        sample(4'd2, 1'b0, 16'sd30000, 1'b0);
        fill(16'sd0, 7, 16'sd77);
        run_frame(1'b0, 1'b0);
        exp_cnt++;
        checks++; if (o_digit !== 4'd7 || o_score !== 16'sd77) begin errors++; $display("FAIL ignore_pre got=%0d/%h exp=7/004d", o_digit, o_score); end
        for (int k = 0; k < 6; k++) sample(4'(k), (k == 0), 16'sd9, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0 || o_digit !== 4'd0 || o_score !== 16'sd0) begin errors++; $display("FAIL async_rst_data got=%b/%0d/%h exp=0/0/0000", o_valid, o_digit, o_score); end
        checks++; if (o_frame_cnt !== 16'd0) begin errors++; $display("FAIL async_rst_cnt got=%0d exp=0", o_frame_cnt); end
        @(negedge clk); rst_n = 1'b1; sv = 1'b0;
        exp_cnt = 0;
        // Remaining classes of the interrupted frame must not complete anything.
        for (int k = 6; k < 10; k++) sample(4'(k), 1'b0, 16'sd9, 1'b1);
        fill(-16'sd5, 3, -16'sd1);
        run_frame(1'b1, 1'b1);
        exp_cnt++;
        checks++; if (o_digit !== 4'd3 || o_score !== 16'shFFFF) begin errors++; $display("FAIL post_rst got=%0d/%h exp=3/ffff", o_digit, o_score); end
        checks++; if (o_frame_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL post_rst_cnt got=%0d exp=%0d", o_frame_cnt, exp_cnt); end
        idle(1'b1);
    endtask

    task automatic test_back_to_back;
        int ovr0;
        ovr0 = ovr_cnt;
        fill(16'sd1, 6, 16'sd60);
        run_frame(1'b0, 1'b0);
        exp_cnt++;
        checks++; if (o_digit !== 4'd6) begin errors++; $display("FAIL b2b_first got=%0d exp=6", o_digit); end
        fill(16'sd1, 0, 16'sd90);
        run_frame(1'b0, 1'b1);
        exp_cnt++;
        checks++; if (o_valid !== 1'b1 || o_digit !== 4'd0 || o_score !== 16'sd90) begin errors++; $display("FAIL b2b_load got=%b/%0d/%h exp=1/0/005a", o_valid, o_digit, o_score); end
        checks++; if (o_overrun !== 1'b0 || ovr_cnt !== ovr0) begin errors++; $display("FAIL b2b_overrun got=%b/%0d exp=0/0", o_overrun, ovr_cnt - ovr0); end
        checks++; if (o_frame_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL b2b_cnt got=%0d exp=%0d", o_frame_cnt, exp_cnt); end
        idle(1'b1);
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_negative;
        test_overrun;
        test_seq_err;
        test_restart;
        test_reset_midframe;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
